// File: rtl/warp_scheduler_pkg.sv
// warp_scheduler_pkg
//   Shared configuration for the warp scheduler slice: warp-table sizing,
//   the issue record handed to fetch (flopWarpData_t) and the per-warp
//   lifecycle state (warpState_t).
package warp_scheduler_pkg;

   localparam int NUM_WARPS            = 8;
   localparam int LOG2_NUM_WARPS       = 3;
   localparam int MACHINE_WIDTH        = 64;
   localparam int NUM_THREADS_PER_WARP = 8;

   typedef struct packed {
      logic [LOG2_NUM_WARPS-1:0]       warp_id;
      logic [MACHINE_WIDTH-1:0]        pc;
      logic [NUM_THREADS_PER_WARP-1:0] mask;
   } flopWarpData_t;

   typedef enum logic [1:0] {
      WS_IDLE     = 2'd0,
      WS_READY    = 2'd1,
      WS_INFLIGHT = 2'd2
   } warpState_t;

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// warp_scheduler_rr_arbiter
//   Combinational round-robin pick over the READY vector. The search starts
//   at rr_ptr and wraps modulo NUM_WARPS; the first requester found wins.
// Ports:
//   req         in   NUM_WARPS       one bit per READY warp
//   rr_ptr      in   LOG2_NUM_WARPS  highest-priority slot this cycle
//   grant_valid out  1               at least one request present
//   grant_id    out  LOG2_NUM_WARPS  winning slot (0 when no grant)
module warp_scheduler_rr_arbiter
   import warp_scheduler_pkg::*;
(
   input  logic [NUM_WARPS-1:0]      req,
   input  logic [LOG2_NUM_WARPS-1:0] rr_ptr,
   output logic                      grant_valid,
   output logic [LOG2_NUM_WARPS-1:0] grant_id
);

   // Walk offsets from farthest to nearest so the nearest hit is written last
   // and wins, avoiding an early exit from the loop.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      for (int k = NUM_WARPS - 1; k >= 0; k--) begin
         logic [LOG2_NUM_WARPS-1:0] idx;
         idx = LOG2_NUM_WARPS'((int'(rr_ptr) + k) % NUM_WARPS);
         if (req[idx]) begin
            grant_valid = 1'b1;
            grant_id    = idx;
         end
      end
   end

endmodule

// File: rtl/warp_scheduler.sv
// warp_scheduler
//   Warp table plus round-robin issue stage feeding fetch/decode. Holds the
//   per-warp pc/mask/state, issues one READY warp per accepted slot into a
//   registered output, and takes next-pc/mask writebacks for in-flight warps.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   spawn_valid/_warp_id/_pc/_mask activate an IDLE slot
//   upd_valid/_warp_id/_pc/_mask   writeback for an INFLIGHT warp (mask 0 ends it)
//   out_valid, out_ready, out_warp issue handshake to fetch
//   spawn_err, upd_err             one-cycle pulses for rejected requests
//   active_count                   number of non-IDLE warps (registered)
//   all_idle                       no active warps and issue slot empty
module warp_scheduler
   import warp_scheduler_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            spawn_valid,
   input  logic [LOG2_NUM_WARPS-1:0]       spawn_warp_id,
   input  logic [MACHINE_WIDTH-1:0]        spawn_pc,
   input  logic [NUM_THREADS_PER_WARP-1:0] spawn_mask,
   input  logic                            upd_valid,
   input  logic [LOG2_NUM_WARPS-1:0]       upd_warp_id,
   input  logic [MACHINE_WIDTH-1:0]        upd_pc,
   input  logic [NUM_THREADS_PER_WARP-1:0] upd_mask,
   output logic                            out_valid,
   input  logic                            out_ready,
   output flopWarpData_t                   out_warp,
   output logic                            spawn_err,
   output logic                            upd_err,
   output logic [LOG2_NUM_WARPS:0]         active_count,
   output logic                            all_idle
);

   warpState_t                      state_q [NUM_WARPS];
   warpState_t                      state_d [NUM_WARPS];
   logic [MACHINE_WIDTH-1:0]        pc_q    [NUM_WARPS];
   logic [NUM_THREADS_PER_WARP-1:0] mask_q  [NUM_WARPS];
   logic [LOG2_NUM_WARPS-1:0]       rr_ptr_q;

   logic [NUM_WARPS-1:0]      ready_vec;
   logic                      grant_valid;
   logic [LOG2_NUM_WARPS-1:0] grant_id;
   logic                      load_en;
   logic                      issue;
   logic                      spawn_ok;
   logic                      upd_ok;
   logic                      out_valid_d;
   logic [LOG2_NUM_WARPS:0]   active_d;

   always_comb begin
      for (int i = 0; i < NUM_WARPS; i++) begin
         ready_vec[i] = (state_q[i] == WS_READY);
      end
   end

   warp_scheduler_rr_arbiter u_arb (
      .req         (ready_vec),
      .rr_ptr      (rr_ptr_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign load_en  = !out_valid || out_ready;
   assign issue    = load_en && grant_valid;
   assign spawn_ok = spawn_valid && (state_q[spawn_warp_id] == WS_IDLE) && (spawn_mask != '0);
   assign upd_ok   = upd_valid && (state_q[upd_warp_id] == WS_INFLIGHT);

   // The three transitions act on warps in distinct current states (READY,
   // IDLE, INFLIGHT), so they can never target the same slot together.
   always_comb begin
      for (int i = 0; i < NUM_WARPS; i++) begin
         state_d[i] = state_q[i];
      end
      if (issue) begin
         state_d[grant_id] = WS_INFLIGHT;
      end
      if (spawn_ok) begin
         state_d[spawn_warp_id] = WS_READY;
      end
      if (upd_ok) begin
         state_d[upd_warp_id] = (upd_mask != '0) ? WS_READY : WS_IDLE;
      end
   end

   always_comb begin
      active_d = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (state_d[i] != WS_IDLE) begin
            active_d = active_d + (LOG2_NUM_WARPS + 1)'(1);
         end
      end
   end

   assign out_valid_d = load_en ? grant_valid : out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            state_q[i] <= WS_IDLE;
            pc_q[i]    <= '0;
            mask_q[i]  <= '0;
         end
         rr_ptr_q     <= '0;
         out_valid    <= 1'b0;
         out_warp     <= '0;
         spawn_err    <= 1'b0;
         upd_err      <= 1'b0;
         active_count <= '0;
         all_idle     <= 1'b1;
      end else begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            state_q[i] <= state_d[i];
         end
         if (spawn_ok) begin
            pc_q[spawn_warp_id]   <= spawn_pc;
            mask_q[spawn_warp_id] <= spawn_mask;
         end
         if (upd_ok) begin
            pc_q[upd_warp_id]   <= upd_pc;
            mask_q[upd_warp_id] <= upd_mask;
         end
         // Issue register: reload whenever the slot is empty or being taken.
         out_valid <= out_valid_d;
         if (issue) begin
            out_warp.warp_id <= grant_id;
            out_warp.pc      <= pc_q[grant_id];
            out_warp.mask    <= mask_q[grant_id];
            rr_ptr_q         <= (grant_id == LOG2_NUM_WARPS'(NUM_WARPS - 1)) ? '0 : grant_id + 1'b1;
         end
         spawn_err    <= spawn_valid && !spawn_ok;
         upd_err      <= upd_valid && !upd_ok;
         active_count <= active_d;
         all_idle     <= (active_d == '0) && !out_valid_d;
      end
   end

endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler
//   Directed, table-driven bench for warp_scheduler: each row drives one
//   cycle of spawn/upd/out_ready and lists the outputs expected right after
//   that clock edge. Hand-written sequences cover reset and mid-stream reset.
module tb_warp_scheduler;
   import warp_scheduler_pkg::*;

   logic                            clk = 1'b0;
   logic                            rst_n;
   logic                            spawn_valid;
   logic [LOG2_NUM_WARPS-1:0]       spawn_warp_id;
   logic [MACHINE_WIDTH-1:0]        spawn_pc;
   logic [NUM_THREADS_PER_WARP-1:0] spawn_mask;
   logic                            upd_valid;
   logic [LOG2_NUM_WARPS-1:0]       upd_warp_id;
   logic [MACHINE_WIDTH-1:0]        upd_pc;
   logic [NUM_THREADS_PER_WARP-1:0] upd_mask;
   logic                            out_valid;
   logic                            out_ready;
   flopWarpData_t                   out_warp;
   logic                            spawn_err;
   logic                            upd_err;
   logic [LOG2_NUM_WARPS:0]         active_count;
   logic                            all_idle;

   always #5 clk = ~clk;

   warp_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .spawn_valid   (spawn_valid),
      .spawn_warp_id (spawn_warp_id),
      .spawn_pc      (spawn_pc),
      .spawn_mask    (spawn_mask),
      .upd_valid     (upd_valid),
      .upd_warp_id   (upd_warp_id),
      .upd_pc        (upd_pc),
      .upd_mask      (upd_mask),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_warp      (out_warp),
      .spawn_err     (spawn_err),
      .upd_err       (upd_err),
      .active_count  (active_count),
      .all_idle      (all_idle)
   );

   typedef struct {
      logic        sv;
      logic [2:0]  sid;
      logic [63:0] spc;
      logic [7:0]  smask;
      logic        uv;
      logic [2:0]  uid;
      logic [63:0] upc;
      logic [7:0]  umask;
      logic        rdy;
      logic        eov;
      logic [2:0]  ewid;
      logic [63:0] epc;
      logic [7:0]  emask;
      logic        ese;
      logic        eue;
      logic [3:0]  eact;
      logic        eidle;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   vec_t tbl [30];

   function automatic vec_t mk(
      input logic sv, input logic [2:0] sid, input logic [63:0] spc, input logic [7:0] smask,
      input logic uv, input logic [2:0] uid, input logic [63:0] upc, input logic [7:0] umask,
      input logic rdy,
      input logic eov, input logic [2:0] ewid, input logic [63:0] epc, input logic [7:0] emask,
      input logic ese, input logic eue, input logic [3:0] eact, input logic eidle);
      vec_t v;
      v.sv = sv;   v.sid = sid;   v.spc = spc;   v.smask = smask;
      v.uv = uv;   v.uid = uid;   v.upc = upc;   v.umask = umask;
      v.rdy = rdy;
      v.eov = eov; v.ewid = ewid; v.epc = epc;   v.emask = emask;
      v.ese = ese; v.eue = eue;   v.eact = eact; v.eidle = eidle;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, row, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int row);
      @(negedge clk);
      spawn_valid   = v.sv;
      spawn_warp_id = v.sid;
      spawn_pc      = v.spc;
      spawn_mask    = v.smask;
      upd_valid     = v.uv;
      upd_warp_id   = v.uid;
      upd_pc        = v.upc;
      upd_mask      = v.umask;
      out_ready     = v.rdy;
      @(posedge clk);
      #1;
      chk("out_valid", row, 64'(out_valid), 64'(v.eov));
      if (v.eov) begin
         chk("warp_id", row, 64'(out_warp.warp_id), 64'(v.ewid));
         chk("pc", row, out_warp.pc, v.epc);
         chk("mask", row, 64'(out_warp.mask), 64'(v.emask));
      end
      chk("spawn_err", row, 64'(spawn_err), 64'(v.ese));
      chk("upd_err", row, 64'(upd_err), 64'(v.eue));
      chk("active_count", row, 64'(active_count), 64'(v.eact));
      chk("all_idle", row, 64'(all_idle), 64'(v.eidle));
   endtask

   initial begin
      //            spawn                 upd                     rdy expected out            se ue act idle
      tbl[0]  = mk(1,3,'h100,'hFF,   0,0,0,0,             1,  0,0,0,0,               0,0,1,0);
      tbl[1]  = mk(0,0,0,0,          0,0,0,0,             1,  1,3,'h100,'hFF,        0,0,1,0);
      tbl[2]  = mk(0,0,0,0,          1,3,'h104,'hFF,      1,  0,0,0,0,               0,0,1,0);
      tbl[3]  = mk(0,0,0,0,          0,0,0,0,             1,  1,3,'h104,'hFF,        0,0,1,0);
      tbl[4]  = mk(0,0,0,0,          1,3,'h108,'h00,      1,  0,0,0,0,               0,0,0,1);
      tbl[5]  = mk(1,0,'h200,'h0F,   0,0,0,0,             1,  0,0,0,0,               0,0,1,0);
      tbl[6]  = mk(1,1,'h300,'hF0,   0,0,0,0,             1,  1,0,'h200,'h0F,        0,0,2,0);
      tbl[7]  = mk(1,2,'h400,'h01,   1,0,'h201,'h0F,      1,  1,1,'h300,'hF0,        0,0,3,0);
      tbl[8]  = mk(0,0,0,0,          1,1,'h301,'hF0,      1,  1,2,'h400,'h01,        0,0,3,0);
      tbl[9]  = mk(0,0,0,0,          1,2,'h401,'h01,      1,  1,0,'h201,'h0F,        0,0,3,0);
      tbl[10] = mk(0,0,0,0,          1,0,'h202,'h0F,      1,  1,1,'h301,'hF0,        0,0,3,0);
      tbl[11] = mk(0,0,0,0,          1,1,'h302,'hF0,      1,  1,2,'h401,'h01,        0,0,3,0);
      // stall with warp 2 held; bad spawn to READY warp 1, bad upd to IDLE warp 6
      tbl[12] = mk(1,1,'hDEAD,'hAA,  1,6,'h666,'h01,      0,  1,2,'h401,'h01,        1,1,3,0);
      tbl[13] = mk(0,0,0,0,          0,0,0,0,             0,  1,2,'h401,'h01,        0,0,3,0);
      tbl[14] = mk(0,0,0,0,          0,0,0,0,             0,  1,2,'h401,'h01,        0,0,3,0);
      tbl[15] = mk(0,0,0,0,          0,0,0,0,             0,  1,2,'h401,'h01,        0,0,3,0);
      tbl[16] = mk(0,0,0,0,          0,0,0,0,             0,  1,2,'h401,'h01,        0,0,3,0);
      tbl[17] = mk(0,0,0,0,          0,0,0,0,             1,  1,0,'h202,'h0F,        0,0,3,0);
      // terminations
      tbl[18] = mk(0,0,0,0,          1,2,'h402,'h00,      1,  1,1,'h302,'hF0,        0,0,2,0);
      tbl[19] = mk(0,0,0,0,          1,0,'h203,'h00,      1,  0,0,0,0,               0,0,1,0);
      tbl[20] = mk(0,0,0,0,          1,1,'h303,'h00,      1,  0,0,0,0,               0,0,0,1);
      tbl[21] = mk(0,0,0,0,          0,0,0,0,             1,  0,0,0,0,               0,0,0,1);
      // zero-mask spawn is rejected
      tbl[22] = mk(1,4,'h4000,'h00,  0,0,0,0,             1,  0,0,0,0,               1,0,0,1);
      // pointer wrap over warps 6, 7, 0
      tbl[23] = mk(1,6,'h600,'h03,   0,0,0,0,             1,  0,0,0,0,               0,0,1,0);
      tbl[24] = mk(1,7,'h700,'h0C,   0,0,0,0,             1,  1,6,'h600,'h03,        0,0,2,0);
      tbl[25] = mk(1,0,'h800,'h80,   1,6,'h601,'h03,      1,  1,7,'h700,'h0C,        0,0,3,0);
      tbl[26] = mk(0,0,0,0,          1,7,'h701,'h0C,      1,  1,0,'h800,'h80,        0,0,3,0);
      tbl[27] = mk(0,0,0,0,          1,0,'h801,'h80,      1,  1,6,'h601,'h03,        0,0,3,0);
      tbl[28] = mk(0,0,0,0,          0,0,0,0,             1,  1,7,'h701,'h0C,        0,0,3,0);
      tbl[29] = mk(0,0,0,0,          0,0,0,0,             1,  1,0,'h801,'h80,        0,0,3,0);

      spawn_valid = 1'b0; spawn_warp_id = '0; spawn_pc = '0; spawn_mask = '0;
      upd_valid   = 1'b0; upd_warp_id   = '0; upd_pc   = '0; upd_mask   = '0;
      out_ready   = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", -1, 64'(out_valid), 64'(0));
      chk("rst_out_warp", -1, 64'(out_warp.pc), 64'(0));
      chk("rst_out_id_mask", -1, 64'({out_warp.warp_id, out_warp.mask}), 64'(0));
      chk("rst_spawn_err", -1, 64'(spawn_err), 64'(0));
      chk("rst_upd_err", -1, 64'(upd_err), 64'(0));
      chk("rst_active_count", -1, 64'(active_count), 64'(0));
      chk("rst_all_idle", -1, 64'(all_idle), 64'(1));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         apply(tbl[i], i);
      end

      // asynchronous reset while warp 0 sits in the issue register
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", 100, 64'(out_valid), 64'(0));
      chk("async_all_idle", 100, 64'(all_idle), 64'(1));
      chk("async_active_count", 100, 64'(active_count), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // same-ID spawn and upd on an IDLE warp: spawn wins, upd flagged
      apply(mk(1,5,'h500,'hFF, 1,5,'h999,'h01, 1, 0,0,0,0,         0,1,1,0), 101);
      apply(mk(0,0,0,0,        0,0,0,0,        1, 1,5,'h500,'hFF,  0,0,1,0), 102);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
Warp table and round-robin warp scheduler. It sits directly upstream of fetch/decode and emits one flopWarpData_t (warpID, pc, mask) per accepted issue. Per-warp PC, mask and state live here. Execute/branch write back the next PC/mask, which makes the warp eligible again. Each warp has at most one instruction in flight, so there are no intra-warp hazards downstream.

Parameters:
NUM_WARPS, 8, number of warp slots
LOG2_NUM_WARPS, 3, warp ID width
MACHINE_WIDTH, 64, PC width
NUM_THREADS_PER_WARP, 8, thread mask width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
spawn_valid  in  1  activate a warp slot
spawn_warp_id  in  LOG2_NUM_WARPS  slot to activate
spawn_pc  in  MACHINE_WIDTH  start PC
spawn_mask  in  NUM_THREADS_PER_WARP  initial thread mask
upd_valid  in  1  writeback of next PC/mask for an in-flight warp
upd_warp_id  in  LOG2_NUM_WARPS  warp being updated
upd_pc  in  MACHINE_WIDTH  next PC
upd_mask  in  NUM_THREADS_PER_WARP  next mask; all-zero terminates the warp
out_valid  out  1  issue slot holds a warp
out_ready  in  1  fetch accepts the warp
out_warp  out  flopWarpData_t  warpID/pc/mask to fetch
spawn_err  out  1  one-cycle pulse: spawn to a non-IDLE slot or with a zero mask (ignored)
upd_err  out  1  one-cycle pulse: update to a non-INFLIGHT warp (ignored)
active_count  out  LOG2_NUM_WARPS+1  number of non-IDLE warps
all_idle  out  1  all warps IDLE and out_valid=0

Behaviour:
- Reset (async, rst_n=0):
  - All warp states IDLE; pc=0; mask=0; rr_ptr=0.
  - out_valid=0; out_warp all zero; spawn_err=0; upd_err=0; active_count=0; all_idle=1.
- Per-warp state machine (2-bit): IDLE -> READY (spawn); READY -> INFLIGHT (selected into out reg); INFLIGHT -> READY (upd, mask!=0); INFLIGHT -> IDLE (upd, mask==0).
- Spawn:
  - Accepted only if the slot is IDLE and spawn_mask!=0.
  - Writes pc/mask and sets state READY at the edge.
  - Otherwise the spawn is ignored and spawn_err pulses next cycle.
- Update:
  - Accepted only if the warp is INFLIGHT; writes pc/mask at the edge.
  - Otherwise the update is ignored and upd_err pulses next cycle.
- Output register:
  - Load enable: load_en = !out_valid || out_ready.
  - When load_en=1, search READY warps starting at rr_ptr, wrapping modulo NUM_WARPS. The first hit is registered into out_warp, out_valid=1, that warp goes INFLIGHT, and rr_ptr = hit+1 (wrapping NUM_WARPS-1 -> 0).
  - No hit: out_valid=0 and rr_ptr unchanged.
  - When out_valid=1 and out_ready=0, out_warp and out_valid hold stable with no change.
- Eligibility uses registered state only; there is no bypass from spawn/upd.
  - Spawn or upd asserted in cycle N gives the earliest out_valid for that warp in cycle N+2.
- Throughput: one warp per cycle while out_ready=1 and at least one warp is READY.
- Simultaneous events:
  - spawn and upd to different warps in the same cycle: both take effect.
  - Same ID: impossible for both to be legal (IDLE vs INFLIGHT); apply the one whose state check passes and flag the other.
  - A warp being selected cannot be updated in the same cycle, since it is READY, not INFLIGHT. Such an upd is flagged.
- active_count and all_idle are registered and reflect the post-edge state.
- Reset mid-operation: everything is cleared immediately. An in-flight out_warp is dropped, and downstream must also be reset.

Decomposition:
- Shared config package: flopWarpData_t, NUM_WARPS, LOG2_NUM_WARPS, NUM_THREADS_PER_WARP, MACHINE_WIDTH, plus a new enum warpState_t {WS_IDLE, WS_READY, WS_INFLIGHT}.
- One sub-module: rr_arbiter.
  - Combinational round-robin priority pick over a NUM_WARPS request vector and rr_ptr.
  - Outputs: grant_valid and grant_id.
- Warp table and state regs stay in warp_scheduler.

Test Plan:
1. Reset, then spawn warp 3 (pc=0x100, mask=0xFF) in cycle 0 with out_ready=1 -> out_valid=1 in cycle 2 with warpID=3, pc=0x100, mask=0xFF; active_count=1.
2. Spawn warps 0, 1, 2 and hold out_ready=1, updating each with pc+1 immediately after issue -> issue order 0,1,2,0,1,2,...; rr_ptr wraps correctly at warp 7 when warps 6, 7, 0 are active.
3. out_ready=0 for 5 cycles with warp 2 issued -> out_warp stays {2, pc, mask}, state of other READY warps unchanged; when out_ready=1, the next READY warp loads the following cycle.
4. Update warp 5 with mask=0 -> warp 5 goes IDLE, active_count decrements, never issued again; after the last warp terminates, all_idle=1.
5. Spawn to a READY warp 4, and upd to an IDLE warp 6 -> spawn_err=1 and upd_err=1 for one cycle each; warp 4 pc/mask unchanged.
6. Assert rst_n=0 asynchronously mid-stream with out_valid=1 -> out_valid=0, all_idle=1, active_count=0 before the next clock edge.
